// File: rtl/sic4_fetch_unit.sv
// SIC-4 instruction-fetch stage: PC, one-byte fetch, valid/ready issue, halt on HALT_OP.
// Optional wait-for-ack timeout enabled with `define FETCH_TIMEOUT_EN.
module sic4_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] next_pc,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic              is_halt_op;
  logic              timeout_hit;

  assign is_halt_op = (instr[DATA_W-1 -: 4] == HALT_OP);

  // State, PC and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
    end
  end

  // Next-state logic; halt takes priority over any branch request
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        if (mem_ack) begin
          instr_nxt = mem_rdata;
          state_nxt = ISSUE;
        end else if (timeout_hit) begin
          state_nxt = HALT;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          if (is_halt_op) begin
            state_nxt = HALT;
          end else begin
            pc_nxt    = next_pc;
            state_nxt = REQ;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == REQ) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Counts REQ cycles; restarts on every entry into REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      wait_cnt <= (state == REQ) ? wait_cnt + CNT_W'(1) : '0;
      if (timeout_hit && !mem_ack) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // Outputs decoded from the state register; pc_sel follows branch_en only while issuing
  assign mem_req     = (state == REQ);
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);
  assign pc_sel      = (state == ISSUE) && branch_en;
  assign mem_addr    = pc;
  assign pc_plus1    = pc + ADDR_W'(1);
  assign branch_addr = branch_target;

endmodule
